echo_mix_stage: RTL and testbench

Downstream consumer of the tapped delay lines. Takes the dry input sample and the wet sample from the currently selected delay line. Produces a saturated echo mix, dry + (wet*gain)/16, through a 2-stage pipeline. Gates the wet path while the lines fill after reset, and ramps the wet gain up on every tap change so switching taps does not click.

---
 rtl/delay_pkg.sv | 21 ++
 rtl/echo_mix_stage_if.sv | 27 ++
 rtl/echo_gain_ctrl.sv | 119 +++++++++++
 rtl/echo_mix_stage.sv | 97 +++++++++
 tb/tb_echo_mix_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
// Shared definitions for the echo mix stage and its gain controller.
// Holds the default sample/gain/counter widths, the per-tap delay line
// depths, the gain ramp step length and the controller state encoding.
package delay_pkg;

  localparam int WIDTH    = 8;
  localparam int GAIN_W   = 4;
  localparam int CNT_W    = 7;
  localparam int DEPTH0   = 30;
  localparam int DEPTH1   = 45;
  localparam int DEPTH2   = 60;
  localparam int DEPTH3   = 90;
  localparam int RAMP_LEN = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    RAMP = 2'd2
  } state_t;

endpackage

// File: rtl/echo_mix_stage_if.sv
// Sample/control bundle of the echo mix stage.
//   in_valid, dry_in, wet_in, tap_sel, gain : driven by the source (master)
//   mix_out, out_valid, state_o, busy       : driven by the mix stage (slave)
interface echo_mix_stage_if #(
  parameter int WIDTH  = 8,
  parameter int GAIN_W = 4
);
  logic              in_valid;
  logic [WIDTH-1:0]  dry_in;
  logic [WIDTH-1:0]  wet_in;
  logic [1:0]        tap_sel;
  logic [GAIN_W-1:0] gain;
  logic [WIDTH-1:0]  mix_out;
  logic              out_valid;
  logic [1:0]        state_o;
  logic              busy;

  modport master (
    output in_valid, dry_in, wet_in, tap_sel, gain,
    input  mix_out, out_valid, state_o, busy
  );

  modport slave (
    input  in_valid, dry_in, wet_in, tap_sel, gain,
    output mix_out, out_valid, state_o, busy
  );
endinterface

// File: rtl/echo_gain_ctrl.sv
// Wet gain controller for the echo mix stage.
// Holds the wet path at zero gain while the delay lines fill after reset,
// then tracks the requested gain. On a tap change it ramps the gain from
// zero up to the target one step every RAMP_LEN clocks to avoid clicks.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   tap_sel   : currently selected delay line
//   gain      : target wet gain (1/16 units)
//   eff_gain  : gain actually applied to the wet path
//   state     : FILL / RUN / RAMP
//   busy      : high whenever state is not RUN
module echo_gain_ctrl
  import delay_pkg::*;
#(
  parameter int GAIN_W_P   = GAIN_W,
  parameter int CNT_W_P    = CNT_W,
  parameter int DEPTH0_P   = DEPTH0,
  parameter int DEPTH1_P   = DEPTH1,
  parameter int DEPTH2_P   = DEPTH2,
  parameter int DEPTH3_P   = DEPTH3,
  parameter int RAMP_LEN_P = RAMP_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          tap_sel,
  input  logic [GAIN_W_P-1:0] gain,
  output logic [GAIN_W_P-1:0] eff_gain,
  output state_t              state,
  output logic                busy
);

  state_t               state_reg, state_next;
  logic [CNT_W_P-1:0]   cnt_reg, cnt_next;
  logic [GAIN_W_P-1:0]  eff_reg, eff_next;
  logic [1:0]           tap_q_reg;
  logic [CNT_W_P-1:0]   depth_sel;
  logic                 tap_change;

  // Fill threshold follows the live tap selection, so a tap change during
  // FILL only moves the compare point.
  always_comb begin
    depth_sel = CNT_W_P'(DEPTH0_P);
    case (tap_sel)
      2'd0: depth_sel = CNT_W_P'(DEPTH0_P);
      2'd1: depth_sel = CNT_W_P'(DEPTH1_P);
      2'd2: depth_sel = CNT_W_P'(DEPTH2_P);
      2'd3: depth_sel = CNT_W_P'(DEPTH3_P);
      default: depth_sel = CNT_W_P'(DEPTH0_P);
    endcase
  end

  assign tap_change = (tap_sel != tap_q_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      eff_reg   <= '0;
      tap_q_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      eff_reg   <= eff_next;
      tap_q_reg <= tap_sel;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    eff_next   = eff_reg;
    case (state_reg)
      FILL: begin
        // Counts clocks, not samples: the lines shift every clock.
        eff_next = '0;
        if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
        if (cnt_reg >= depth_sel) begin
          state_next = RUN;
          eff_next   = gain;
        end
      end
      RUN: begin
        if (tap_change) begin
          state_next = RAMP;
          eff_next   = '0;
          cnt_next   = '0;
        end else begin
          eff_next = gain;
        end
      end
      RAMP: begin
        if (tap_change) begin
          // Another switch restarts the ramp from silence.
          eff_next = '0;
          cnt_next = '0;
        end else if (eff_reg >= gain) begin
          // Covers both reaching the target and the target dropping below.
          state_next = RUN;
          eff_next   = gain;
        end else if (cnt_reg == CNT_W_P'(RAMP_LEN_P - 1)) begin
          cnt_next = '0;
          eff_next = eff_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = FILL;
        cnt_next   = '0;
        eff_next   = '0;
      end
    endcase
  end

  assign eff_gain = eff_reg;
  assign state    = state_reg;
  assign busy     = (state_reg != RUN);

endmodule

// File: rtl/echo_mix_stage.sv
// Echo mixer: mix_out = saturate(dry + (wet * eff_gain) / 16) through a
// two-stage pipeline (capture, then multiply/add/saturate). The wet gain
// comes from echo_gain_ctrl, which mutes the wet path during line fill and
// ramps it after tap changes.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of echo_mix_stage_if (samples, tap, gain in;
//              mix_out/out_valid/state_o/busy out)
module echo_mix_stage
  import delay_pkg::*;
#(
  parameter int WIDTH_P    = WIDTH,
  parameter int GAIN_W_P   = GAIN_W,
  parameter int CNT_W_P    = CNT_W,
  parameter int DEPTH0_P   = DEPTH0,
  parameter int DEPTH1_P   = DEPTH1,
  parameter int DEPTH2_P   = DEPTH2,
  parameter int DEPTH3_P   = DEPTH3,
  parameter int RAMP_LEN_P = RAMP_LEN
) (
  input  logic           clk,
  input  logic           rst,
  echo_mix_stage_if.slave bus
);

  localparam int PROD_W = WIDTH_P + GAIN_W_P;

  logic [GAIN_W_P-1:0] eff_gain;
  state_t              state;
  logic                busy;

  echo_gain_ctrl #(
    .GAIN_W_P   (GAIN_W_P),
    .CNT_W_P    (CNT_W_P),
    .DEPTH0_P   (DEPTH0_P),
    .DEPTH1_P   (DEPTH1_P),
    .DEPTH2_P   (DEPTH2_P),
    .DEPTH3_P   (DEPTH3_P),
    .RAMP_LEN_P (RAMP_LEN_P)
  ) u_gain_ctrl (
    .clk      (clk),
    .rst      (rst),
    .tap_sel  (bus.tap_sel),
    .gain     (bus.gain),
    .eff_gain (eff_gain),
    .state    (state),
    .busy     (busy)
  );

  // Stage 1: sample capture together with the gain in force at that clock.
  logic [WIDTH_P-1:0]  dry1_reg, wet1_reg;
  logic [GAIN_W_P-1:0] gain1_reg;
  logic                v1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dry1_reg  <= '0;
      wet1_reg  <= '0;
      gain1_reg <= '0;
      v1_reg    <= 1'b0;
    end else begin
      v1_reg <= bus.in_valid;
      if (bus.in_valid) begin
        dry1_reg  <= bus.dry_in;
        wet1_reg  <= bus.wet_in;
        gain1_reg <= eff_gain;
      end
    end
  end

  // Stage 2: scale wet by gain/16, add dry, clip to full scale.
  logic [PROD_W-1:0]  prod;
  logic [WIDTH_P:0]   sum;
  logic [WIDTH_P-1:0] sat;
  logic [WIDTH_P-1:0] mix_reg;
  logic               out_valid_reg;

  assign prod = PROD_W'(wet1_reg) * PROD_W'(gain1_reg);
  assign sum  = {1'b0, dry1_reg} + (WIDTH_P + 1)'(prod >> GAIN_W_P);
  assign sat  = sum[WIDTH_P] ? '1 : sum[WIDTH_P-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mix_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= v1_reg;
      if (v1_reg) mix_reg <= sat;  // hold last value through gaps
    end
  end

  assign bus.mix_out   = mix_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.state_o   = state;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_echo_mix_stage.sv
module tb_echo_mix_stage;

  localparam int S_FILL = 0;
  localparam int S_RUN  = 1;
  localparam int S_RAMP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  echo_mix_stage_if #(.WIDTH(8), .GAIN_W(4)) bus ();

  echo_mix_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int exp_mix;
  int exp_st;
  logic pat [5];

  initial begin
    bus.in_valid = 1'b0;
    bus.dry_in   = '0;
    bus.wet_in   = '0;
    bus.tap_sel  = 2'd0;
    bus.gain     = '0;

    // 1: fill on tap 0, then saturated mix
    bus.tap_sel = 2'd0; bus.gain = 4'd15;
    bus.dry_in = 8'd100; bus.wet_in = 8'd200; bus.in_valid = 1'b1;
    do_reset();
    chk("rst_state", bus.state_o, S_FILL);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_mix", bus.mix_out, 0);
    chk("rst_busy", bus.busy, 1);
    tick(30);
    chk("fill_state_c30", bus.state_o, S_FILL);
    chk("fill_mix_dry", bus.mix_out, 100);
    tick();
    chk("fill_to_run", bus.state_o, S_RUN);
    chk("run_busy", bus.busy, 0);
    tick();
    chk("run_mix_lag", bus.mix_out, 100);
    tick();
    chk("run_mix_sat", bus.mix_out, 255);
    $display("test1 fill+saturate: state=%0d mix=%0d", bus.state_o, bus.mix_out);

    // 2: single pulse latency
    bus.in_valid = 1'b0; bus.gain = 4'd8;
    tick(3);
    bus.dry_in = 8'd40; bus.wet_in = 8'd80; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("pulse_v_1clk", bus.out_valid, 0);
    tick();
    chk("pulse_v_2clk", bus.out_valid, 1);
    chk("pulse_mix", bus.mix_out, 80);
    tick();
    chk("pulse_v_3clk", bus.out_valid, 0);
    chk("pulse_hold", bus.mix_out, 80);
    $display("test2 pulse: mix=%0d", bus.mix_out);

    // 3: tap change ramp 0 -> 40 in 10-unit steps
    bus.gain = 4'd4; bus.dry_in = 8'd0; bus.wet_in = 8'd160; bus.in_valid = 1'b1;
    tick(3);
    chk("pre_ramp_mix", bus.mix_out, 40);
    bus.tap_sel = 2'd3;
    tick();
    chk("ramp_enter", bus.state_o, S_RAMP);
    chk("ramp_busy", bus.busy, 1);
    for (int k = 1; k <= 70; k++) begin
      tick();
      exp_st  = (k <= 64) ? S_RAMP : S_RUN;
      exp_mix = (k < 2) ? 40 : 10 * (((k - 2) / 16 > 4) ? 4 : (k - 2) / 16);
      chk($sformatf("ramp_state_k%0d", k), bus.state_o, exp_st);
      chk($sformatf("ramp_mix_k%0d", k), bus.mix_out, exp_mix);
    end
    $display("test3 ramp: state=%0d mix=%0d", bus.state_o, bus.mix_out);

    // 4: reset mid-ramp restarts fill from zero
    bus.tap_sel = 2'd0;
    tick();
    chk("ramp2_enter", bus.state_o, S_RAMP);
    tick(20);
    do_reset();
    chk("mid_rst_state", bus.state_o, S_FILL);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_mix", bus.mix_out, 0);
    tick(30);
    chk("refill_c30", bus.state_o, S_FILL);
    chk("refill_mix_muted", bus.mix_out, 0);
    tick();
    chk("refill_run", bus.state_o, S_RUN);
    $display("test4 mid-ramp reset: state=%0d", bus.state_o);

    // 5: tap switch during fill only moves the threshold
    bus.tap_sel = 2'd3;
    do_reset();
    tick(40);
    chk("fill_tap3_c40", bus.state_o, S_FILL);
    bus.tap_sel = 2'd0;
    tick();
    chk("fill_switch_run", bus.state_o, S_RUN);
    tick();
    chk("fill_switch_noramp", bus.state_o, S_RUN);
    chk("fill_switch_mix0", bus.mix_out, 0);
    tick();
    chk("fill_switch_gain", bus.mix_out, 40);
    $display("test5 fill tap switch: state=%0d mix=%0d", bus.state_o, bus.mix_out);

    // 6: valid gaps with zero gain
    bus.in_valid = 1'b0; bus.gain = 4'd0; bus.wet_in = 8'd200;
    tick(3);
    chk("gap_pre_hold", bus.mix_out, 40);
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0;
    exp_mix = 40;
    for (int t = 0; t < 7; t++) begin
      bus.in_valid = (t < 5) ? pat[t] : 1'b0;
      bus.dry_in   = 8'(t + 1);
      tick();
      if (t >= 1) begin
        if (pat[t-1]) exp_mix = t;  // dry of the input at index t-1
        chk($sformatf("gap_v_t%0d", t), bus.out_valid, int'(pat[t-1]));
        chk($sformatf("gap_mix_t%0d", t), bus.mix_out, exp_mix);
        $display("test6 t=%0d out_valid=%0d mix=%0d", t, bus.out_valid, bus.mix_out);
      end
      if (t == 5) break;
    end

    // 7: tap change with zero gain: one-clock ramp
    bus.tap_sel = 2'd1;
    tick();
    chk("g0_ramp", bus.state_o, S_RAMP);
    tick();
    chk("g0_run", bus.state_o, S_RUN);
    $display("test7 zero-gain tap change: state=%0d", bus.state_o);

    // 8: gain drop below ramped gain exits to RUN
    bus.gain = 4'd8;
    tick(2);
    bus.tap_sel = 2'd2;
    tick();
    chk("drop_ramp", bus.state_o, S_RAMP);
    tick(20);
    chk("drop_still_ramp", bus.state_o, S_RAMP);
    bus.gain = 4'd0;
    tick();
    chk("drop_run", bus.state_o, S_RUN);
    $display("test8 gain drop: state=%0d", bus.state_o);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
